// File: rtl/ula_multiciclo_if.sv
`default_nettype none
// ============================================================================
// Module : ula_multiciclo_if
// Brief  : Start/busy/done handshake and operand/result bus for ula_multiciclo.
// Rev    : 1.0
// ============================================================================
interface ula_multiciclo_if #(
  parameter int LARGURA = 32
);
  logic               inicio;
  logic [4:0]         controle;
  logic [LARGURA-1:0] A;
  logic [LARGURA-1:0] B;
  logic [LARGURA-1:0] resultado;
  logic               zero;
  logic               desvio;
  logic               ocupado;
  logic               pronto;
  logic               erro;

  modport master (
    output inicio, controle, A, B,
    input  resultado, zero, desvio, ocupado, pronto, erro
  );

  modport slave (
    input  inicio, controle, A, B,
    output resultado, zero, desvio, ocupado, pronto, erro
  );
endinterface
`default_nettype wire

// File: rtl/ula_multiciclo.sv
`default_nettype none
// ============================================================================
// Module : ula_multiciclo
// Brief  : Multi-cycle ALU; define ULA_MULTDIV_EN for iterative mult/div/mod.
// Rev    : 1.0
// ============================================================================
module ula_multiciclo #(
  parameter int LARGURA = 32
) (
  input  logic              clock,
  input  logic              reset,
  ula_multiciclo_if.slave   bus
);
  localparam int c_SH = $clog2(LARGURA);

  logic [LARGURA-1:0] r_resultado;
  logic               r_zero, r_desvio, r_erro, r_pronto;
  logic [LARGURA-1:0] w_res, w_dif;
  logic               w_desvio, w_erro, w_iter, w_aceita, w_menor, w_maior;

`ifdef ULA_MULTDIV_EN
  localparam int                c_CW      = $clog2(LARGURA);
  localparam logic [c_CW-1:0]   c_ULTIMO  = c_CW'(LARGURA - 1);

  typedef enum logic [1:0] {OCIOSO = 2'd0, CALC = 2'd1, AJUSTE = 2'd2} estado_t;
  estado_t            r_estado;
  logic               r_ocupado, r_neg_q, r_neg_r;
  logic [1:0]         r_op;
  logic [c_CW-1:0]    r_cont;
  logic [LARGURA:0]   r_rem;
  logic [LARGURA-1:0] r_q, r_d;
  logic [LARGURA-1:0] w_mag_a, w_mag_b, w_ajuste;
  logic [LARGURA:0]   w_trial;

  always_comb begin
    w_mag_a = bus.A[LARGURA-1] ? -bus.A : bus.A;
    w_mag_b = bus.B[LARGURA-1] ? -bus.B : bus.B;
    // Restoring step: shift next dividend bit in, try subtracting the divisor
    w_trial = {r_rem[LARGURA-1:0], r_q[LARGURA-1]} - {1'b0, r_d};
    case (r_op)
      2'b00:   w_ajuste = r_neg_q ? -r_rem[LARGURA-1:0] : r_rem[LARGURA-1:0];
      2'b01:   w_ajuste = r_neg_q ? -r_q : r_q;
      default: w_ajuste = r_neg_r ? -r_rem[LARGURA-1:0] : r_rem[LARGURA-1:0];
    endcase
  end

  assign w_aceita    = bus.inicio && (r_estado == OCIOSO);
  assign bus.ocupado = r_ocupado;
`else
  assign w_aceita    = bus.inicio;
  assign bus.ocupado = 1'b0;
`endif

  assign w_dif   = bus.A - bus.B;
  assign w_menor = $signed(bus.A) < $signed(bus.B);
  assign w_maior = $signed(bus.A) > $signed(bus.B);

  always_comb begin
    w_res    = '0;
    w_desvio = 1'b0;
    w_erro   = 1'b0;
    w_iter   = 1'b0;
    case (bus.controle)
      5'd0:  w_res = bus.A + bus.B;
      5'd1:  w_res = w_dif;
      5'd2:  w_res = bus.A & bus.B;
      5'd3:  w_res = bus.A | bus.B;
      5'd4:  w_res = ~bus.A;
      5'd5:  w_res = bus.A << bus.B[c_SH-1:0];
      5'd6:  w_res = bus.A >> bus.B[c_SH-1:0];
      5'd7:  begin w_res = w_dif; w_desvio = (bus.A == bus.B); end
      5'd8:  begin w_res = w_dif; w_desvio = (bus.A != bus.B); end
      5'd9:  begin w_res = w_dif; w_desvio = bus.A[LARGURA-1]; end
      5'd10: w_res = {{(LARGURA-1){1'b0}}, w_menor};
      5'd11: w_res = {{(LARGURA-1){1'b0}}, w_maior};
`ifdef ULA_MULTDIV_EN
      5'd12: w_iter = 1'b1;
      5'd13: if (bus.B == '0) begin w_res = '1; w_erro = 1'b1; end
             else w_iter = 1'b1;
      5'd14: if (bus.B == '0) begin w_res = bus.A; w_erro = 1'b1; end
             else w_iter = 1'b1;
`endif
      5'd15: w_res = bus.A ^ bus.B;
      5'd16: w_res = ~(bus.A & bus.B);
      5'd17: w_res = ~(bus.A | bus.B);
      5'd18: begin w_res = w_dif; w_desvio = w_menor; end
      5'd19: begin w_res = w_dif; w_desvio = w_maior; end
      default: w_erro = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_resultado <= '0;
      r_zero      <= 1'b1;
      r_desvio    <= 1'b0;
      r_erro      <= 1'b0;
      r_pronto    <= 1'b0;
`ifdef ULA_MULTDIV_EN
      r_estado    <= OCIOSO;
      r_ocupado   <= 1'b0;
      r_cont      <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_op        <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
`endif
    end else begin
      r_pronto <= 1'b0;
      if (w_aceita && !w_iter) begin
        r_resultado <= w_res;
        r_zero      <= (w_res == '0);
        r_desvio    <= w_desvio;
        r_erro      <= w_erro;
        r_pronto    <= 1'b1;
      end
`ifdef ULA_MULTDIV_EN
      case (r_estado)
        OCIOSO: if (w_aceita && w_iter) begin
          r_op      <= bus.controle[1:0];
          r_neg_q   <= bus.A[LARGURA-1] ^ bus.B[LARGURA-1];
          r_neg_r   <= bus.A[LARGURA-1];
          r_q       <= w_mag_a;
          r_d       <= w_mag_b;
          r_rem     <= '0;
          r_cont    <= '0;
          r_ocupado <= 1'b1;
          r_estado  <= CALC;
        end
        CALC: begin
          // Multiply is shift-add on magnitudes; only the low word is kept
          if (r_op == 2'b00) begin
            r_rem <= {1'b0, r_rem[LARGURA-1:0] + (r_q[0] ? r_d : '0)};
            r_d   <= r_d << 1;
            r_q   <= r_q >> 1;
          end else if (!w_trial[LARGURA]) begin
            r_rem <= w_trial;
            r_q   <= {r_q[LARGURA-2:0], 1'b1};
          end else begin
            r_rem <= {r_rem[LARGURA-1:0], r_q[LARGURA-1]};
            r_q   <= {r_q[LARGURA-2:0], 1'b0};
          end
          r_cont <= r_cont + 1'b1;
          if (r_cont == c_ULTIMO) r_estado <= AJUSTE;
        end
        AJUSTE: begin
          r_resultado <= w_ajuste;
          r_zero      <= (w_ajuste == '0);
          r_desvio    <= 1'b0;
          r_erro      <= 1'b0;
          r_pronto    <= 1'b1;
          r_ocupado   <= 1'b0;
          r_estado    <= OCIOSO;
        end
        default: r_estado <= OCIOSO;
      endcase
`endif
    end
  end

  assign bus.resultado = r_resultado;
  assign bus.zero      = r_zero;
  assign bus.desvio    = r_desvio;
  assign bus.erro      = r_erro;
  assign bus.pronto    = r_pronto;

endmodule
`default_nettype wire
